// File: rtl/uart_tx_core.sv
// UART transmitter: FIFO-buffered byte stream serialized LSB-first as start, 8 data, [parity], stop.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_core #(
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      cfg_div_i,
  input  logic             cfg_par_odd_i,
  input  logic [7:0]       data_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             cts_n_i,
  output logic             tx_o,
  output logic             busy_o,
  output logic [LVL_W-1:0] fifo_level_o
);

  localparam int PTR_W = LVL_W - 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t           state_r, state_n_s;
  logic [15:0]      baud_r, baud_n_s;
  logic [15:0]      div_r, div_n_s;
  logic [2:0]       bit_r, bit_n_s;
  logic [7:0]       shift_r, shift_n_s;
  logic             tx_r, tx_n_s;
  logic [7:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic [7:0]       head_s;
  logic             push_s, pop_s, start_ok_s, load_s;

`ifdef UART_TX_PARITY_EN
  logic par_r, par_n_s;

  function automatic logic parity_bit(input logic [7:0] b, input logic odd);
    return (^b) ^ odd;
  endfunction
`else
  logic unused_par_s;
  assign unused_par_s = cfg_par_odd_i;
`endif

  assign ready_o      = (level_r != LVL_W'(FIFO_DEPTH));
  assign push_s       = valid_i & ready_o;
  assign head_s       = mem_r[rd_ptr_r];
  assign start_ok_s   = (level_r != {LVL_W{1'b0}}) & ~cts_n_i;
  assign tx_o         = tx_r;
  assign busy_o       = (state_r != ST_IDLE) | (level_r != {LVL_W{1'b0}});
  assign fifo_level_o = level_r;

  // FIFO storage; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= data_i;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Frame state register; tx idles high so reset releases the line at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      baud_r  <= 16'd0;
      div_r   <= 16'd0;
      bit_r   <= 3'd0;
      shift_r <= 8'd0;
      tx_r    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_n_s;
      baud_r  <= baud_n_s;
      div_r   <= div_n_s;
      bit_r   <= bit_n_s;
      shift_r <= shift_n_s;
      tx_r    <= tx_n_s;
`ifdef UART_TX_PARITY_EN
      par_r   <= par_n_s;
`endif
    end
  end

  // Next-state logic: tx value is computed for the bit that starts on the next edge
  always_comb begin
    state_n_s = state_r;
    baud_n_s  = baud_r;
    div_n_s   = div_r;
    bit_n_s   = bit_r;
    shift_n_s = shift_r;
    tx_n_s    = tx_r;
    load_s    = 1'b0;
    pop_s     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n_s   = par_r;
`endif
    case (state_r)
      ST_IDLE: begin
        tx_n_s = 1'b1;
        load_s = start_ok_s;
      end
      ST_START: begin
        if (baud_r == 16'd0) begin
          state_n_s = ST_DATA;
          tx_n_s    = shift_r[0];
          shift_n_s = {1'b0, shift_r[7:1]};
          bit_n_s   = 3'd0;
          baud_n_s  = div_r;
        end else begin
          baud_n_s = baud_r - 16'd1;
        end
      end
      ST_DATA: begin
        if (baud_r == 16'd0) begin
          baud_n_s = div_r;
          if (bit_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n_s = ST_PARITY;
            tx_n_s    = par_r;
`else
            state_n_s = ST_STOP;
            tx_n_s    = 1'b1;
`endif
          end else begin
            bit_n_s   = bit_r + 3'd1;
            tx_n_s    = shift_r[0];
            shift_n_s = {1'b0, shift_r[7:1]};
          end
        end else begin
          baud_n_s = baud_r - 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_r == 16'd0) begin
          state_n_s = ST_STOP;
          tx_n_s    = 1'b1;
          baud_n_s  = div_r;
        end else begin
          baud_n_s = baud_r - 16'd1;
        end
      end
`endif
      ST_STOP: begin
        if (baud_r == 16'd0) begin
          state_n_s = ST_IDLE;
          tx_n_s    = 1'b1;
          load_s    = start_ok_s;
        end else begin
          baud_n_s = baud_r - 16'd1;
        end
      end
      default: begin
        state_n_s = ST_IDLE;
        tx_n_s    = 1'b1;
      end
    endcase

    // Frame start overrides: pop head byte, latch divider, drive start bit
    if (load_s) begin
      state_n_s = ST_START;
      pop_s     = 1'b1;
      shift_n_s = head_s;
      div_n_s   = cfg_div_i;
      baud_n_s  = cfg_div_i;
      bit_n_s   = 3'd0;
      tx_n_s    = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_n_s   = parity_bit(head_s, cfg_par_odd_i);
`endif
    end else begin
      pop_s = 1'b0;
    end
  end

endmodule
